// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default sizes for the memory port arbiter.
package mem_arb_pkg;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH = 5;
   localparam int DEF_ADDR_W = 3;
   localparam int DEF_NREQ = 2;
   typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after index last.
module rr_arbiter #(
   parameter int N = 2,
   parameter int IW = N > 1 ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);
   logic [IW-1:0] cand;
   assign any = |req;
   // Scan from lowest to highest priority so the highest-priority hit is written last.
   always_comb begin
      gnt = '0;
      idx = '0;
      cand = '0;
      for (int i = N; i >= 1; i--) begin
         cand = IW'((int'(last) + i) % N);
         if (req[cand]) begin
            gnt = '0;
            gnt[cand] = 1'b1;
            idx = cand;
         end
      end
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of a single-port word memory between requesters.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH = DEF_DEPTH,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NREQ = DEF_NREQ
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ-1:0]        req_we,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*DATA_W-1:0] req_wdata,
   output logic [NREQ-1:0]        gnt,
   output logic                   err,
   output logic [NREQ-1:0]        rvalid,
   output logic [DATA_W-1:0]      rdata,
   output logic                   mem_en,
   output logic                   mem_we,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [DATA_W-1:0]      mem_wdata,
   input  logic [DATA_W-1:0]      mem_rdata
);
   localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
   state_t state, state_nx;
   logic [IW-1:0] last, win_idx;
   logic [NREQ-1:0] win_oh;
   logic any, sel_we, sel_oor;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
      .req(req),
      .last(last),
      .gnt(win_oh),
      .idx(win_idx),
      .any(any)
   );
   assign sel_we = req_we[win_idx];
   assign sel_addr = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
   assign sel_wdata = req_wdata[int'(win_idx)*DATA_W +: DATA_W];
   assign sel_oor = int'(sel_addr) >= DEPTH;
   always_ff @(posedge clk)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   // In ACCESS the registered strobe tells an in-range read apart from writes and rejected accesses.
   always_comb begin
      state_nx = IDLE;
      state_nx = state == IDLE ? (any ? ACCESS : IDLE) :
                 state == ACCESS && mem_en && !mem_we ? RD_WAIT : IDLE;
   end
   always_ff @(posedge clk)
      if (!rst_n) begin
         last <= IW'(NREQ-1);
         gnt <= '0;
         err <= 1'b0;
         rvalid <= '0;
         rdata <= '0;
         mem_en <= 1'b0;
         mem_we <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
      end else begin
         gnt <= '0;
         err <= 1'b0;
         rvalid <= '0;
         mem_en <= 1'b0;
         if (state == IDLE && any) begin
            gnt <= win_oh;
            last <= win_idx;
            err <= sel_oor;
            mem_en <= !sel_oor;
            if (!sel_oor) begin
               mem_we <= sel_we;
               mem_addr <= sel_addr;
               mem_wdata <= sel_wdata;
            end
         end
         if (state == RD_WAIT) begin
            rdata <= mem_rdata;
            rvalid <= NREQ'(1) << last;
         end
      end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
   localparam int DATA_W = 8, DEPTH = 5, ADDR_W = 3, NREQ = 2;
   logic clk = 1'b0, rst_n;
   logic [NREQ-1:0] req, req_we, gnt, rvalid;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_wdata;
   logic err, mem_en, mem_we;
   logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_env [DEPTH];
   logic [DATA_W-1:0] mem_m [DEPTH];
   logic [DATA_W-1:0] rdata_m;
   int last_m, checks = 0, errors = 0;
   mem_port_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NREQ(NREQ)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .gnt(gnt), .err(err), .rvalid(rvalid), .rdata(rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );
   always #5 clk = ~clk;
   // Memory array behind the port: read data appears the cycle after the strobe.
   always @(posedge clk)
      if (mem_en) begin
         if (mem_we) mem_env[mem_addr] <= mem_wdata;
         else mem_rdata <= mem_env[mem_addr];
      end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, " gnt"}, gnt, 0);
      chk({tag, " err"}, err, 0);
      chk({tag, " rvalid"}, rvalid, 0);
      chk({tag, " rdata"}, rdata, 0);
      chk({tag, " mem_en"}, mem_en, 0);
      chk({tag, " mem_we"}, mem_we, 0);
      chk({tag, " mem_addr"}, mem_addr, 0);
      chk({tag, " mem_wdata"}, mem_wdata, 0);
   endtask
   // One complete transaction started in an IDLE cycle; returns in the next IDLE cycle.
   task automatic xact(input string tag, input logic [1:0] rv, input logic [1:0] wv,
                       input logic [2:0] a0, input logic [2:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
      int w, j;
      logic [2:0] a;
      logic [7:0] d;
      logic we, oor;
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
         j = (last_m + k) % NREQ;
         if (w < 0 && rv[j]) w = j;
      end
      req = rv; req_we = wv; req_addr = {a1, a0}; req_wdata = {d1, d0};
      step();
      a = w == 0 ? a0 : a1;
      d = w == 0 ? d0 : d1;
      we = wv[w];
      oor = a >= DEPTH;
      chk({tag, " gnt"}, gnt, 32'(1) << w);
      chk({tag, " err"}, err, oor);
      chk({tag, " mem_en"}, mem_en, !oor);
      chk({tag, " rvalid@gnt"}, rvalid, 0);
      if (!oor) begin
         chk({tag, " mem_we"}, mem_we, we);
         chk({tag, " mem_addr"}, mem_addr, a);
         if (we) chk({tag, " mem_wdata"}, mem_wdata, d);
      end
      last_m = w;
      req = '0;
      if (!oor && we) mem_m[a] = d;
      step();
      chk({tag, " gnt off"}, gnt, 0);
      chk({tag, " err off"}, err, 0);
      chk({tag, " mem_en off"}, mem_en, 0);
      if (oor || we) chk({tag, " rdata hold"}, rdata, rdata_m);
      else begin
         chk({tag, " rvalid early"}, rvalid, 0);
         step();
         rdata_m = mem_m[a];
         chk({tag, " rvalid"}, rvalid, 32'(1) << w);
         chk({tag, " rdata"}, rdata, rdata_m);
         chk({tag, " gnt@rvalid"}, gnt, 0);
      end
   endtask
   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_env[i] = '0;
         mem_m[i] = '0;
      end
      mem_rdata = '0;
      rdata_m = '0;
      last_m = NREQ - 1;
      rst_n = 1'b0; req = 2'b11; req_we = '0; req_addr = '0; req_wdata = '0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_zero("reset");
      end
      rst_n = 1'b1;
      step();
      chk("post-reset gnt", gnt, 2'b01);
      last_m = 0;
      req = '0;
      step();
      step();
      chk("post-reset rvalid", rvalid, 2'b01);
      chk("post-reset rdata", rdata, 0);
      xact("write", 2'b01, 2'b01, 3'd3, 3'd0, 8'hA5, 8'h00);
      xact("read", 2'b01, 2'b00, 3'd3, 3'd0, 8'h00, 8'h00);
      xact("oor", 2'b10, 2'b00, 3'd0, 3'd5, 8'h00, 8'h00);
      req = 2'b11; req_we = 2'b11; req_addr = {3'd2, 3'd1}; req_wdata = {8'h22, 8'h11};
      for (int i = 0; i < 4; i++) begin
         step();
         last_m = (last_m + 1) % NREQ;
         chk("contention gnt", gnt, 32'(1) << last_m);
         mem_m[last_m == 0 ? 1 : 2] = last_m == 0 ? 8'h11 : 8'h22;
         step();
         chk("contention gap", gnt, 0);
      end
      req = '0;
      xact("after oor", 2'b10, 2'b00, 3'd0, 3'd2, 8'h00, 8'h00);
      req = 2'b01; req_we = 2'b00; req_addr = {3'd4, 3'd2};
      step();
      chk("drop gnt", gnt, 2'b01);
      last_m = 0;
      req = 2'b10;
      step();
      req = '0;
      chk("drop no gnt", gnt, 0);
      chk("drop no err", err, 0);
      step();
      rdata_m = mem_m[2];
      chk("drop rvalid", rvalid, 2'b01);
      chk("drop rdata", rdata, rdata_m);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("drop never gnt", gnt, 0);
         chk("drop never err", err, 0);
      end
      req = 2'b01; req_we = 2'b00; req_addr = {3'd0, 3'd3};
      step();
      chk("rst-mid gnt", gnt, 2'b01);
      req = '0;
      step();
      rst_n = 1'b0;
      step();
      chk_zero("rst-mid");
      rst_n = 1'b1;
      last_m = NREQ - 1;
      rdata_m = '0;
      step();
      chk("rst-mid no rvalid", rvalid, 0);
      chk("rst-mid no gnt", gnt, 0);
      xact("after rst", 2'b11, 2'b00, 3'd3, 3'd1, 8'h00, 8'h00);
      for (int i = 0; i < 40; i++)
         xact("random", 2'($urandom_range(1, 3)), 2'($urandom), 3'($urandom_range(0, 6)),
              3'($urandom_range(0, 6)), 8'($urandom), 8'($urandom));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
